// File: rtl/ritc_storage_readout_ctrl_pkg.sv
// Shared types and field widths for the RITC storage readout sequencer.
package ritc_storage_readout_ctrl_pkg;

    localparam int BLOCK_W     = 3;
    localparam int WORD_W      = 10;
    localparam int DATA_W      = 24;
    localparam int STOR_ADDR_W = BLOCK_W + WORD_W;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        TRIG,
        WAIT_LOW,
        WAIT_DONE,
        ADDR,
        LAT,
        PRESENT,
        FINISH
    } state_t;

endpackage

// File: rtl/ritc_readout_cursor.sv
// Channel/word cursor for the storage readout: clears to chan0/idx0, steps idx
// with wrap into the next channel, and flags the final word of the run.
module ritc_readout_cursor
    import ritc_storage_readout_ctrl_pkg::*;
#(
    parameter int NUM_CHAN = 6,
    parameter int DEPTH    = 1024
) (
    input  logic               user_clk_i,
    input  logic               rst_n_i,
    input  logic               clr,
    input  logic               adv,
    output logic [BLOCK_W-1:0] chan,
    output logic [WORD_W-1:0]  idx,
    output logic [BLOCK_W-1:0] nxt_chan,
    output logic [WORD_W-1:0]  nxt_idx,
    output logic               last
);

    localparam logic [BLOCK_W-1:0] CHAN_MAX = BLOCK_W'(NUM_CHAN - 1);
    localparam logic [WORD_W-1:0]  IDX_MAX  = WORD_W'(DEPTH - 1);

    logic idx_wrap;

    assign idx_wrap = (idx == IDX_MAX);
    assign last     = idx_wrap && (chan == CHAN_MAX);
    assign nxt_idx  = idx_wrap ? '0 : idx + 1'b1;
    assign nxt_chan = idx_wrap ? chan + 1'b1 : chan;

    always_ff @(posedge user_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chan <= '0;
            idx  <= '0;
        end else if (clr) begin
            chan <= '0;
            idx  <= '0;
        end else if (adv) begin
            chan <= nxt_chan;
            idx  <= nxt_idx;
        end
    end

endmodule

// File: rtl/ritc_storage_readout_ctrl.sv
// RITC storage readout sequencer: clear, trigger, wait for capture, then read every
// word by explicit address onto a valid/ready stream. Optional capture watchdog: RITC_READOUT_TIMEOUT_EN.
module ritc_storage_readout_ctrl
    import ritc_storage_readout_ctrl_pkg::*;
#(
    parameter int NUM_CHAN = 6,
    parameter int DEPTH    = 1024,
    parameter int RD_LAT   = 2,
    parameter int TIMEOUT  = 1048576
) (
    input  logic                   user_clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   sync_latch_o,
    output logic                   timeout_o,
    output logic                   stor_trig_o,
    output logic                   stor_clear_o,
    output logic                   stor_sel_o,
    output logic                   stor_rd_o,
    output logic                   stor_wr_o,
    output logic [STOR_ADDR_W-1:0] stor_addr_o,
    input  logic [31:0]            stor_dat_i,
    input  logic                   stor_done_i,
    input  logic                   stor_sync_latch_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_W-1:0]      out_dat_o,
    output logic [BLOCK_W-1:0]     out_chan_o,
    output logic [WORD_W-1:0]      out_idx_o,
    output logic                   out_last_o
);

    state_t             state, state_nx;
    logic [2:0]         lat_cnt;
    logic               lat_end, to_hit, waiting;
    logic [BLOCK_W-1:0] cur_chan, nxt_chan;
    logic [WORD_W-1:0]  cur_idx, nxt_idx;
    logic               cur_last;
    logic               unused_dat_hi;

    assign lat_end       = (lat_cnt == 3'(RD_LAT - 1));
    assign waiting       = (state == WAIT_LOW) || (state == WAIT_DONE);
    assign stor_rd_o     = 1'b0;
    assign unused_dat_hi = &{1'b0, stor_dat_i[31:24]};

`ifdef RITC_READOUT_TIMEOUT_EN
    logic [20:0] to_cnt;

    always_ff @(posedge user_clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     to_cnt <= '0;
        else if (waiting) to_cnt <= to_cnt + 21'd1;
        else              to_cnt <= '0;
    end

    assign to_hit = waiting && (to_cnt == 21'(TIMEOUT - 1));
`else
    // Watchdog compiled out: the wait for capture complete is unbounded.
    assign to_hit = (TIMEOUT < 0);
`endif

    ritc_readout_cursor #(.NUM_CHAN(NUM_CHAN), .DEPTH(DEPTH)) u_cursor (
        .user_clk_i (user_clk_i),
        .rst_n_i    (rst_n_i),
        .clr        (state == WAIT_DONE && state_nx == ADDR),
        .adv        (state == PRESENT && (state_nx == ADDR || state_nx == FINISH)),
        .chan       (cur_chan),
        .idx        (cur_idx),
        .nxt_chan   (nxt_chan),
        .nxt_idx    (nxt_idx),
        .last       (cur_last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (start_i) state_nx = CLEAR;
            CLEAR:     state_nx = TRIG;
            TRIG:      state_nx = WAIT_LOW;
            WAIT_LOW:  if (!stor_done_i) state_nx = WAIT_DONE;
            WAIT_DONE: if (stor_done_i) state_nx = ADDR;
            ADDR:      state_nx = LAT;
            LAT:       if (lat_end) state_nx = PRESENT;
            PRESENT:   if (out_ready_i) state_nx = cur_last ? FINISH : ADDR;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort_i || to_hit) state_nx = IDLE;
    end

    // Outputs are decoded from the next state so every strobe leaves a flop.
    always_ff @(posedge user_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            sync_latch_o <= 1'b0;
            timeout_o    <= 1'b0;
            stor_trig_o  <= 1'b0;
            stor_clear_o <= 1'b0;
            stor_sel_o   <= 1'b0;
            stor_wr_o    <= 1'b0;
            stor_addr_o  <= '0;
            out_valid_o  <= 1'b0;
            out_dat_o    <= '0;
            out_chan_o   <= '0;
            out_idx_o    <= '0;
            out_last_o   <= 1'b0;
        end else begin
            state        <= state_nx;
            lat_cnt      <= (state == LAT) ? lat_cnt + 3'd1 : 3'd0;
            busy_o       <= (state_nx != IDLE);
            done_o       <= (state_nx == FINISH);
            stor_clear_o <= (state_nx == CLEAR);
            stor_trig_o  <= (state_nx == TRIG);
            stor_sel_o   <= (state_nx == ADDR);
            stor_wr_o    <= (state_nx == ADDR);
            out_valid_o  <= (state_nx == PRESENT);
            if (state_nx == ADDR)
                stor_addr_o <= (state == PRESENT) ? {nxt_chan, nxt_idx} : '0;
            if (state == LAT && state_nx == PRESENT) begin
                out_dat_o  <= stor_dat_i[DATA_W-1:0];
                out_chan_o <= cur_chan;
                out_idx_o  <= cur_idx;
                out_last_o <= cur_last;
            end
            if (state == WAIT_DONE && state_nx == ADDR)
                sync_latch_o <= stor_sync_latch_i;
            if (state == IDLE && state_nx == CLEAR)
                timeout_o <= 1'b0;
            else if (to_hit)
                timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ritc_storage_readout_ctrl.sv
// Scoreboard bench for ritc_storage_readout_ctrl: expected words are queued at start,
// a negedge monitor pops and compares every accepted word and every address strobe.
module tb_ritc_storage_readout_ctrl;

    localparam int NUM_CHAN = 6;
    localparam int DEPTH    = 1024;
    localparam int RD_LAT   = 2;
    localparam int WORDS    = NUM_CHAN * DEPTH;
`ifdef RITC_READOUT_TIMEOUT_EN
    localparam int TIMEOUT  = 100;
`else
    localparam int TIMEOUT  = 1048576;
`endif

    typedef struct packed {
        logic [2:0]  chan;
        logic [9:0]  idx;
        logic        last;
        logic [23:0] data;
    } word_t;

    logic        user_clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0, abort_i = 1'b0;
    logic        busy_o, done_o, sync_latch_o, timeout_o;
    logic        stor_trig_o, stor_clear_o, stor_sel_o, stor_rd_o, stor_wr_o;
    logic [12:0] stor_addr_o;
    logic [31:0] stor_dat_i;
    logic        stor_done_i = 1'b1, stor_sync_latch_i = 1'b0;
    logic        out_valid_o, out_ready_i = 1'b1;
    logic [23:0] out_dat_o;
    logic [2:0]  out_chan_o;
    logic [9:0]  out_idx_o;
    logic        out_last_o;

    int          n_tests = 0, n_fail = 0, n_words = 0;
    word_t       exp_q[$];
    logic        exp_sync = 1'b0;
    logic [23:0] key = '0;
    logic [23:0] pipe [RD_LAT];
    logic [7:0]  dat_hi = '0;
    word_t       cur, held, e;
    logic        hold_pend = 1'b0, last_hs = 1'b0;

    always #5 user_clk_i = ~user_clk_i;

    ritc_storage_readout_ctrl #(
        .NUM_CHAN(NUM_CHAN), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .user_clk_i(user_clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .sync_latch_o(sync_latch_o), .timeout_o(timeout_o),
        .stor_trig_o(stor_trig_o), .stor_clear_o(stor_clear_o), .stor_sel_o(stor_sel_o),
        .stor_rd_o(stor_rd_o), .stor_wr_o(stor_wr_o), .stor_addr_o(stor_addr_o),
        .stor_dat_i(stor_dat_i), .stor_done_i(stor_done_i), .stor_sync_latch_i(stor_sync_latch_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_dat_o(out_dat_o),
        .out_chan_o(out_chan_o), .out_idx_o(out_idx_o), .out_last_o(out_last_o)
    );

    // Storage model: strobed address content appears RD_LAT cycles later, noise otherwise.
    assign stor_dat_i = {dat_hi, pipe[RD_LAT-1]};
    always @(posedge user_clk_i) begin
        pipe[0] <= (stor_sel_o && stor_wr_o) ? (24'(stor_addr_o) ^ key) : 24'($urandom);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        dat_hi <= 8'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge user_clk_i) begin
        if (rst_n_i) begin
            cur = {out_chan_o, out_idx_o, out_last_o, out_dat_o};
            if (last_hs || done_o) check("done_pulse", done_o, last_hs);
            if (hold_pend && out_valid_o) check("stall_stable", cur, held);
            if (stor_sel_o) begin
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("strobe_addr", {stor_rd_o, stor_wr_o, stor_addr_o},
                          {2'b01, exp_q[0].chan, exp_q[0].idx});
            end
            last_hs = 1'b0;
            if (out_valid_o && out_ready_i) begin
                check("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word", cur, e);
                    check("sync_latch", sync_latch_o, exp_sync);
                end
                last_hs = out_last_o;
                n_words++;
            end
            hold_pend = out_valid_o && !out_ready_i;
            held = cur;
        end
    end

    task automatic step();
        @(posedge user_clk_i);
        #1;
    endtask

    task automatic push_run();
        for (int c = 0; c < NUM_CHAN; c++)
            for (int i = 0; i < DEPTH; i++)
                exp_q.push_back({3'(c), 10'(i), (c == NUM_CHAN-1 && i == DEPTH-1),
                                 24'(c * 1024 + i) ^ key});
    endtask

    task automatic start_run(input logic sync, input int fall_dly, input int rise_dly);
        logic early;
        push_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("clear_pulse", {stor_clear_o, stor_trig_o, busy_o, timeout_o}, 4'b1010);
        step();
        check("trig_pulse", {stor_clear_o, stor_trig_o}, 2'b01);
        early = 1'b0;
        repeat (fall_dly - 1) begin step(); early |= stor_sel_o; end
        stor_done_i = 1'b0;
        repeat (rise_dly) begin step(); early |= stor_sel_o; end
        check("no_early_strobe", early, 0);
        stor_done_i = 1'b1;
        stor_sync_latch_i = sync;
        step();
        check("first_strobe", {stor_sel_o, stor_wr_o, stor_addr_o}, {2'b11, 13'd0});
        exp_sync = sync;
        stor_sync_latch_i = ~sync;
    endtask

    task automatic run_until_abort(input int ac, input int ai);
        int cyc = 0;
        logic hit = 1'b0;
        while (!hit && cyc < 5 * WORDS) begin
            start_i = (cyc == 5);
            if (out_valid_o && out_chan_o == 3'(ac) && out_idx_o == 10'(ai)) begin
                hit = 1'b1;
                out_ready_i = 1'b0;
                abort_i = 1'b1;
            end else begin
                out_ready_i = ($urandom_range(0, 3) != 0);
            end
            step();
            cyc++;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        check("abort_reached", hit, 1);
        check("abort_idle", {busy_o, out_valid_o, done_o}, 3'b000);
        exp_q.delete();
        repeat (20) step();
        check("abort_quiet", {busy_o, stor_sel_o, out_valid_o}, 3'b000);
        out_ready_i = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, stall;
        logic got, stalled;
        repeat (3) @(posedge user_clk_i);
        #1;
        check("reset_outputs",
              {busy_o, done_o, sync_latch_o, timeout_o, stor_trig_o, stor_clear_o, stor_sel_o,
               stor_rd_o, stor_wr_o, stor_addr_o, out_valid_o, out_dat_o, out_chan_o,
               out_idx_o, out_last_o}, 64'd0);
        rst_n_i = 1'b1;
        step();

        // Run 1: full readout, data = address, stale done, 10-cycle stall at chan2/idx17.
        key = '0;
        start_run(1'b1, 3, 50);
        cyc = 0; stall = 0; got = 1'b0; stalled = 1'b0;
        while (!got && cyc < 4 * WORDS + 200) begin
            if (stall > 0) begin
                out_ready_i = 1'b0;
                stall--;
            end else if (!stalled && out_valid_o && out_chan_o == 3'd2 && out_idx_o == 10'd17) begin
                out_ready_i = 1'b0;
                stall = 9;
                stalled = 1'b1;
            end else begin
                out_ready_i = 1'b1;
            end
            step();
            cyc++;
            got = done_o;
        end
        check("run1_done_latency", cyc, (1 + RD_LAT + 1) * WORDS + 10);
        check("run1_word_count", n_words, WORDS);
        check("run1_queue_empty", exp_q.size(), 0);
        step();
        check("run1_idle", {busy_o, done_o, out_valid_o}, 3'b000);

        // Run 2: random data and backpressure, abort at chan3/idx500.
        key = 24'($urandom);
        start_run(1'b0, $urandom_range(1, 5), $urandom_range(1, 20));
        run_until_abort(3, 500);

        // start and abort together in IDLE: abort wins.
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        check("start_abort_idle", {busy_o, stor_clear_o}, 2'b00);

        // Run 3: a fresh start reads again from chan0/idx0.
        key = 24'($urandom);
        start_run(1'($urandom), $urandom_range(1, 5), $urandom_range(1, 20));
        run_until_abort(0, 20);

        // Capture never completes.
        stor_done_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
`ifdef RITC_READOUT_TIMEOUT_EN
        repeat (TIMEOUT - 2) step();
        check("timeout_before", {timeout_o, busy_o}, 2'b01);
        repeat (4) step();
        check("timeout_after", {timeout_o, busy_o}, 2'b10);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("timeout_cleared", {timeout_o, stor_clear_o}, 2'b01);
`else
        repeat (300) step();
        check("unbounded_wait", {timeout_o, busy_o}, 2'b01);
`endif
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("final_idle", {busy_o, done_o}, 2'b00);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ritc_storage_readout_ctrl.md
# ritc_storage_readout_ctrl

Sequencer for the RITC sample-storage block, running on the user clock. On a start request it clears the storage, issues a capture trigger and waits for the storage to report capture complete. It then reads every stored 24-bit word of channels A–F by explicit address and presents them on a valid/ready stream tagged with channel and index. It sits between the storage block's user bus and the event-readout path, replacing software-driven register reads.

## Interface
- NUM_CHAN, 6: channels read out, blocks 0..NUM_CHAN-1; range 1..8.
- DEPTH, 1024: words per channel; power of two, 2..1024.
- RD_LAT, 2: cycles from address strobe to valid storage data; range 1..7.
- TIMEOUT, 1048576: capture watchdog limit in cycles; used only with the timeout feature.
- user_clk_i, in, 1: the block's single clock.
- rst_n_i, in, 1: reset, asynchronous assert, active-low.
- start_i, in, 1: one-cycle start request; ignored unless idle.
- abort_i, in, 1: abandons the current run and returns to IDLE.
- busy_o, out, 1: high in every state except IDLE.
- done_o, out, 1: one-cycle pulse after the last word is accepted.
- sync_latch_o, out, 1: stor_sync_latch_i, registered on entry to READ.
- timeout_o, out, 1: sticky timeout flag; cleared by start_i.
- stor_trig_o / stor_clear_o, out, 1 each: one-cycle pulses to storage.
- stor_sel_o / stor_rd_o / stor_wr_o, out, 1 each: storage user-bus strobes.
- stor_addr_o, out, 13: {block[2:0], word[9:0]}.
- stor_dat_i, in, 32: storage read data; bits [23:0] are used.
- stor_done_i, in, 1: storage capture complete, already in user-clock domain.
- stor_sync_latch_i, in, 1: sync level latched at storage address 0.
- out_valid_o, out, 1: output stream valid.
- out_ready_i, in, 1: output stream ready.
- out_dat_o, out, 24: eight 3-bit samples.
- out_chan_o, out, 3: channel tag.
- out_idx_o, out, 10: word index tag.
- out_last_o, out, 1: marks the final word of the run.

## Operation
- States: IDLE, CLEAR, TRIG, WAIT_LOW, WAIT_DONE, ADDR, LAT, PRESENT, FINISH.
- IDLE: on start_i, go to CLEAR and clear timeout_o.
- CLEAR: pulse stor_clear_o for one cycle, then go to TRIG.
- TRIG: pulse stor_trig_o for one cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for stor_done_i=0. This guards against a stale done from the previous run.
- WAIT_DONE: wait for stor_done_i=1, then register sync_latch_o, set chan=0 and idx=0, and go to ADDR.
- ADDR: drive stor_sel_o=1 and stor_wr_o=1 for one cycle, with stor_addr_o={chan,idx}. stor_rd_o is never asserted. Every word is read by explicit address write, never by auto-increment. Then go to LAT.
- LAT: count RD_LAT cycles. On the last cycle, register stor_dat_i[23:0] into out_dat_o, load the tags and go to PRESENT.
- PRESENT: hold out_valid_o=1 with data and tags stable until out_ready_i=1.
- On handshake: increment idx. Wrap idx at DEPTH-1 to 0 and increment chan. After chan=NUM_CHAN-1 and idx=DEPTH-1, go to FINISH; otherwise go to ADDR.
- out_last_o=1 only for chan=NUM_CHAN-1 and idx=DEPTH-1.
- FINISH: pulse done_o for one cycle, then go to IDLE.
- abort_i: takes priority in any state. Next state is IDLE, out_valid_o drops, and no done_o pulse is issued. The storage contents are left unchanged.
- If start_i and abort_i arrive together in IDLE, abort wins and the start is dropped.
- stor_done_i falling during a read phase does not stop the sequencer. Data read after that point is undefined.

## Timing
- Reset values: all outputs 0, state IDLE.
- All outputs are registered.
- Per-word latency with out_ready_i held high: 1 (ADDR) + RD_LAT (LAT) + 1 (PRESENT) cycles. Default is 4 cycles per word, 24576 cycles for 6×1024 words.
- start_i to stor_clear_o: 1 cycle. stor_clear_o to stor_trig_o: 1 cycle.
- stor_done_i rising to the first ADDR strobe: 1 cycle.
- Last handshake to done_o: 1 cycle.

## Configuration
- RITC_READOUT_TIMEOUT_EN defined: a 21-bit counter runs in WAIT_LOW and WAIT_DONE. On reaching TIMEOUT it sets timeout_o and returns to IDLE without pulsing done_o.
- RITC_READOUT_TIMEOUT_EN undefined: no counter, the wait is unbounded, and timeout_o is tied to 0.

## Structure
- Shared package holds:
  - the state enum;
  - the address-field widths: block 3, word 10, data 24;
  - STOR_ADDR_W = 13.
- One sub-module, ritc_readout_cursor: the chan/idx counter with wrap and last detection, parameterised by NUM_CHAN and DEPTH.

## Test plan
- Full run: default parameters, out_ready_i=1, storage model returns data = addr. Expect 6144 words and first word chan0/idx0/data 0x000000. Expect last word chan5/idx1023 with out_last_o=1. done_o pulses once, 24576+overhead cycles after start.
- Backpressure: drop out_ready_i for 10 cycles mid-word, chan2/idx17. Data and tags must stay stable and no index may be skipped or duplicated.
- Stale done: stor_done_i=1 at start, falls 3 cycles after stor_clear_o, rises 50 cycles later. Expect no ADDR strobe before that rise.
- Abort: assert abort_i at chan3/idx500. Expect IDLE next cycle, out_valid_o=0 and no done_o. A new start_i then reads again from chan0/idx0.
- Timeout (macro defined, TIMEOUT=100): hold stor_done_i=0. Expect timeout_o=1 at cycle 100 of waiting and busy_o=0. The next start_i clears timeout_o.
- Sync latch: stor_sync_latch_i=1 at done. Expect sync_latch_o=1 through the whole run.
